// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score keeper: FSM state encoding,
// active-low 7-segment patterns (bit order gfedcba) and BCD limits.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  localparam logic [3:0] BCD_NINE  = 4'd9;

endpackage

// File: rtl/seg7_bcd_decoder.sv
// One BCD digit to an active-low gfedcba segment pattern; blank or a
// non-decimal code turns every segment off.
module seg7_bcd_decoder
  import score_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_score_keeper.sv
// Game score keeper: IDLE/RUN/OVER control, divided score tick, saturating
// BCD score with bonus input, retained high score and per-digit 7-seg drive.
module bcd_score_keeper
  import score_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter int TICK_DIV = 50_000_000,
  parameter int BLANK_LZ = 1
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  gameover,
  input  logic                  bonus_valid,
  input  logic [3:0]            bonus_val,
  input  logic                  show_high,
  output logic                  running,
  output logic                  new_high,
  output logic                  saturated,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   high_bcd,
  output logic [7*DIGITS-1:0]   segs
);

  localparam int                BCD_W    = 4 * DIGITS;
  localparam int                CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [BCD_W-1:0]  ALL_NINE = {DIGITS{BCD_NINE}};

  function automatic logic [3:0] clamp_bonus(input logic [3:0] v);
    return (v > BCD_NINE) ? BCD_NINE : v;
  endfunction

  // Ripple decimal add of a 0..10 increment into digit 0; MSB of the result
  // is the carry out of the top digit (i.e. the sum left the BCD range).
  function automatic logic [BCD_W:0] bcd_add(input logic [BCD_W-1:0] a,
                                            input logic [3:0]       inc);
    logic [BCD_W-1:0] s;
    logic [4:0]       carry;
    logic [4:0]       dsum;
    s     = '0;
    carry = {1'b0, inc};
    for (int i = 0; i < DIGITS; i++) begin
      dsum = {1'b0, a[4*i +: 4]} + carry;
      if (dsum > 5'd9) begin
        s[4*i +: 4] = 4'(dsum - 5'd10);
        carry       = 5'd1;
      end else begin
        s[4*i +: 4] = dsum[3:0];
        carry       = 5'd0;
      end
    end
    return {carry[0], s};
  endfunction

  function automatic logic [BCD_W-1:0] bcd_saturate(input logic [BCD_W:0] r);
    return r[BCD_W] ? ALL_NINE : r[BCD_W-1:0];
  endfunction

  // Bit i set when displayed digit i is a leading zero to be blanked.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] d);
    logic              z;
    logic [DIGITS-1:0] m;
    z = 1'b1;
    m = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      z    = z && (d[4*i +: 4] == 4'd0);
      m[i] = z && (BLANK_LZ != 0);
    end
    return m;
  endfunction

  state_t            state_p0;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt_p0;
  logic [BCD_W-1:0]  score_p0;
  logic [BCD_W-1:0]  high_p0;
  logic              new_high_p0;
  logic              sat_p0;

  logic              enter_run;
  logic              end_game;
  logic              tick;
  logic [3:0]        inc;
  logic [BCD_W:0]    add_res;
  logic [BCD_W-1:0]  score_sum;

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE:    if (start)    state_nxt = RUN;
      RUN:     if (gameover) state_nxt = OVER;
      OVER:    if (start)    state_nxt = RUN;
      default:               state_nxt = IDLE;
    endcase
  end

  assign enter_run = (state_p0 != RUN) && start;
  assign end_game  = (state_p0 == RUN) && gameover;
  assign tick      = (state_p0 == RUN) && (cnt_p0 == CNT_LAST);
  assign inc       = {3'b000, tick} + (bonus_valid ? clamp_bonus(bonus_val) : 4'd0);
  assign add_res   = bcd_add(score_p0, inc);
  assign score_sum = bcd_saturate(add_res);

  // ---- stage p0: control, tick divider, score and high-score registers ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p0    <= IDLE;
      cnt_p0      <= '0;
      score_p0    <= '0;
      high_p0     <= '0;
      new_high_p0 <= 1'b0;
      sat_p0      <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      if (enter_run) begin
        cnt_p0      <= '0;
        score_p0    <= '0;
        new_high_p0 <= 1'b0;
        sat_p0      <= 1'b0;
      end else if (end_game) begin
        // Packed BCD orders the same as the decimal value it encodes.
        if (score_p0 > high_p0) begin
          high_p0     <= score_p0;
          new_high_p0 <= 1'b1;
        end
      end else if (state_p0 == RUN) begin
        cnt_p0   <= tick ? '0 : cnt_p0 + CNT_W'(1);
        score_p0 <= score_sum;
        sat_p0   <= (score_sum == ALL_NINE);
      end
    end
  end

  assign running   = (state_p0 == RUN);
  assign new_high  = new_high_p0;
  assign saturated = sat_p0;
  assign score_bcd = score_p0;
  assign high_bcd  = high_p0;

  // ---- display: combinational from the p0 registers ----
  logic [BCD_W-1:0]  disp_bcd;
  logic [DIGITS-1:0] disp_blank;

  assign disp_bcd   = show_high ? high_p0 : score_p0;
  assign disp_blank = blank_mask(disp_bcd);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seg7_bcd_decoder u_dec (
      .bcd   (disp_bcd[4*g +: 4]),
      .blank (disp_blank[g]),
      .seg   (segs[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_bcd_score_keeper.sv
// Scoreboard bench for bcd_score_keeper: integer game model feeds an
// expectation queue that a monitor drains once per clock.
module tb_bcd_score_keeper;

  localparam int DIGITS   = 3;
  localparam int TICK_DIV = 4;
  localparam int BLANK_LZ = 1;
  localparam int MAXV     = 999;

  localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic                  gameover = 1'b0;
  logic                  bonus_valid = 1'b0;
  logic [3:0]            bonus_val = 4'd0;
  logic                  show_high = 1'b0;
  logic                  running;
  logic                  new_high;
  logic                  saturated;
  logic [4*DIGITS-1:0]   score_bcd;
  logic [4*DIGITS-1:0]   high_bcd;
  logic [7*DIGITS-1:0]   segs;

  bcd_score_keeper #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .BLANK_LZ(BLANK_LZ)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .gameover    (gameover),
    .bonus_valid (bonus_valid),
    .bonus_val   (bonus_val),
    .show_high   (show_high),
    .running     (running),
    .new_high    (new_high),
    .saturated   (saturated),
    .score_bcd   (score_bcd),
    .high_bcd    (high_bcd),
    .segs        (segs)
  );

  always #5 clk = ~clk;

  typedef struct {
    int score;
    int high;
    bit run;
    bit nh;
    bit sat;
    bit sh;
  } exp_t;

  exp_t expq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // game model: 0 = idle, 1 = run, 2 = over
  int m_state = 0;
  int m_score = 0;
  int m_high  = 0;
  int m_cycles = 0;
  bit m_nh = 1'b0;

  function automatic logic [4*DIGITS-1:0] to_bcd(int v);
    logic [4*DIGITS-1:0] r;
    int p;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [7*DIGITS-1:0] exp_segs(int v);
    logic [7*DIGITS-1:0] r;
    int p;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (BLANK_LZ != 0 && i > 0 && v < p) r[7*i +: 7] = 7'h7F;
      else                                  r[7*i +: 7] = SEG_TAB[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic m_step(input bit st, input bit go, input bit bv, input int bval);
    int inc;
    if (m_state == 1) begin
      if (go) begin
        if (m_score > m_high) begin
          m_high = m_score;
          m_nh   = 1'b1;
        end
        m_state = 2;
      end else begin
        inc = ((m_cycles % TICK_DIV) == TICK_DIV - 1) ? 1 : 0;
        m_cycles++;
        if (bv) inc += (bval > 9) ? 9 : bval;
        m_score = (m_score + inc > MAXV) ? MAXV : m_score + inc;
      end
    end else if (st) begin
      m_state  = 1;
      m_score  = 0;
      m_cycles = 0;
      m_nh     = 1'b0;
    end
  endtask

  task automatic cycle(input bit st, input bit go, input bit bv, input int bval, input bit sh);
    exp_t e;
    @(negedge clk);
    start       = st;
    gameover    = go;
    bonus_valid = bv;
    bonus_val   = 4'(bval);
    show_high   = sh;
    m_step(st, go, bv, bval);
    e.score = m_score;
    e.high  = m_high;
    e.run   = (m_state == 1);
    e.nh    = m_nh;
    e.sat   = (m_score == MAXV);
    e.sh    = sh;
    expq.push_back(e);
  endtask

  // Bonus-feed until the score equals t in the cycle just before a tick.
  task automatic reach(input int t);
    int guard;
    int rem;
    int b;
    guard = 0;
    while (!(m_score == t && (m_cycles % TICK_DIV) == TICK_DIV - 1) && guard < 3000) begin
      rem = t - m_score;
      if ((m_cycles % TICK_DIV) == TICK_DIV - 1) b = (rem - 1 > 9) ? 9 : rem - 1;
      else                                       b = (rem > 9) ? 9 : rem;
      if (b < 0) b = 0;
      cycle(1'b0, 1'b0, b > 0, b, 1'($urandom_range(0, 1)));
      guard++;
    end
    if (guard >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL reach_%0d: cycle budget expired at model score %0d", t, m_score);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("score", 32'(score_bcd), 32'(to_bcd(e.score)));
        chk("high", 32'(high_bcd), 32'(to_bcd(e.high)));
        chk("running", 32'(running), 32'(e.run));
        chk("new_high", 32'(new_high), 32'(e.nh));
        chk("saturated", 32'(saturated), 32'(e.sat));
        chk("segs", 32'(segs), 32'(exp_segs(e.sh ? e.high : e.score)));
      end
    end
  end

  initial begin
    #1 reset = 1'b0;
    #11;
    chk("rst_score", 32'(score_bcd), 32'h000);
    chk("rst_high", 32'(high_bcd), 32'h000);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_new_high", 32'(new_high), 32'd0);
    chk("rst_saturated", 32'(saturated), 32'd0);
    chk("rst_segs", 32'(segs), 32'({7'h7F, 7'h7F, 7'h40}));
    @(negedge clk);
    reset = 1'b1;

    cycle(1'b0, 1'b1, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
    repeat (40) cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);
    settle();
    chk("score_40cyc", 32'(score_bcd), 32'h010);
    chk("segs_40cyc", 32'(segs), 32'({7'h7F, 7'h79, 7'h40}));
    chk("running_40cyc", 32'(running), 32'd1);

    reach(20);
    cycle(1'b0, 1'b1, 1'b0, 0, 1'b0);

    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
    reach(37);
    cycle(1'b0, 1'b1, 1'b0, 0, 1'b1);
    settle();
    chk("go37_high", 32'(high_bcd), 32'h037);
    chk("go37_new_high", 32'(new_high), 32'd1);
    chk("go37_running", 32'(running), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
    settle();
    chk("restart_score", 32'(score_bcd), 32'h000);
    chk("restart_new_high", 32'(new_high), 32'd0);
    chk("restart_high", 32'(high_bcd), 32'h037);

    reach(12);
    cycle(1'b1, 1'b1, 1'b1, 3, 1'b0);
    settle();
    chk("go_prio_score", 32'(score_bcd), 32'h012);
    chk("go_prio_running", 32'(running), 32'd0);

    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
    reach(98);
    cycle(1'b0, 1'b0, 1'b1, 5, 1'b0);
    settle();
    chk("tick_bonus_carry", 32'(score_bcd), 32'h104);
    reach(995);
    cycle(1'b0, 1'b0, 1'b1, 9, 1'b0);
    settle();
    chk("sat_score", 32'(score_bcd), 32'h999);
    chk("sat_flag", 32'(saturated), 32'd1);
    repeat (8) cycle(1'b0, 1'b0, 1'b1, 15, 1'b0);
    settle();
    chk("sat_hold", 32'(score_bcd), 32'h999);
    cycle(1'b0, 1'b1, 1'b0, 0, 1'b1);

    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
    reach(250);
    settle();
    start       = 1'b0;
    gameover    = 1'b0;
    bonus_valid = 1'b0;
    bonus_val   = 4'd0;
    show_high   = 1'b1;
    reset       = 1'b0;
    #1;
    chk("arst_score", 32'(score_bcd), 32'h000);
    chk("arst_high", 32'(high_bcd), 32'h000);
    chk("arst_running", 32'(running), 32'd0);
    chk("arst_segs", 32'(segs), 32'(exp_segs(0)));
    m_state  = 0;
    m_score  = 0;
    m_high   = 0;
    m_cycles = 0;
    m_nh     = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
    repeat (800) begin
      cycle(1'($urandom_range(0, 99) < 4), 1'($urandom_range(0, 99) < 3),
            1'($urandom_range(0, 99) < 40), int'($urandom_range(0, 15)),
            1'($urandom_range(0, 99) < 20));
    end
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
